reaction_test_ctrl: RTL

//  Central sequencer for the reaction-tester datapath. Replaces the per-signal control flip-flops.

---
 rtl/reaction_pkg.sv | 20 ++
 rtl/reaction_test_ctrl_if.sv | 24 ++
 rtl/tick_divider.sv | 21 ++
 rtl/reaction_test_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-tester control path.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    ACTIVE = 3'd2,
    DONE   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int unsigned ELAPSED_W = 14;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/reaction_test_ctrl_if.sv
// Key inputs and display/LED control outputs of the reaction-test sequencer.
interface reaction_test_ctrl_if;
  import reaction_pkg::*;

  logic                 request_test;
  logic                 stop_test;
  logic                 test_active;
  logic                 enable_bcd;
  logic                 clear_bcd;
  logic                 false_start;
  logic                 timeout;
  logic                 busy;
  logic [ELAPSED_W-1:0] elapsed;

  modport master (
    output request_test, stop_test,
    input  test_active, enable_bcd, clear_bcd, false_start, timeout, busy, elapsed
  );

  modport slave (
    input  request_test, stop_test,
    output test_active, enable_bcd, clear_bcd, false_start, timeout, busy, elapsed
  );
endinterface

// File: rtl/tick_divider.sv
// Divides CLOCK_50 into a one-cycle tick every TICK_DIV cycles; restart realigns the phase.
module tick_divider #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK_50) begin
    if (reset || restart || cnt == LAST) cnt <= '0;
    else                                 cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/reaction_test_ctrl.sv
// Reaction-test sequencer: random pre-stimulus delay, timed stimulus window,
// BCD counter enable/clear and false-start / timeout reporting.
module reaction_test_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV         = 500000,
  parameter int unsigned MIN_DELAY_TICKS  = 100,
  parameter int unsigned DELAY_RANGE_LOG2 = 9,
  parameter int unsigned MAX_TICKS        = 9999
) (
  input logic           CLOCK_50,
  input logic           reset,
  reaction_test_ctrl_if.slave bus
);
  localparam int unsigned DW = $clog2(MIN_DELAY_TICKS + (1 << DELAY_RANGE_LOG2) + 1);
  localparam logic [ELAPSED_W-1:0] MAX_E = ELAPSED_W'(MAX_TICKS);

  state_t               state, state_next;
  logic                 req_q, stop_q, req_rise, stop_rise;
  logic [15:0]          lfsr;
  logic [DW-1:0]        delay_cnt, delay_d;
  logic [ELAPSED_W-1:0] elapsed_d, elapsed_inc;
  logic                 tick, restart, start_wait, max_hit;
  logic                 test_active_d, enable_d, clear_d, false_d, timeout_d, busy_d;

  assign req_rise    = bus.request_test & ~req_q;
  assign stop_rise   = bus.stop_test & ~stop_q;
  assign elapsed_inc = (bus.elapsed >= MAX_E) ? bus.elapsed : bus.elapsed + 1'b1;
  assign max_hit     = (elapsed_inc == MAX_E);

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .restart  (restart),
    .tick     (tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE, FAULT: if (req_rise) state_next = WAIT;
      WAIT: begin
        if (stop_rise)                          state_next = FAULT;
        else if (tick && delay_cnt <= DW'(1))   state_next = ACTIVE;
      end
      ACTIVE: begin
        if (stop_rise)            state_next = DONE;
        else if (tick && max_hit) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs are computed from the upcoming state so they line up with it.
  always_comb begin
    start_wait    = (state_next == WAIT) && (state != WAIT);
    restart       = start_wait || ((state_next == ACTIVE) && (state != ACTIVE));
    test_active_d = (state_next == ACTIVE);
    busy_d        = (state_next == WAIT) || (state_next == ACTIVE);
    false_d       = (state_next == FAULT);
    clear_d       = start_wait;
    enable_d      = (state == ACTIVE) && tick && !stop_rise;
    timeout_d     = (state_next == DONE) &&
                    ((state == DONE) ? bus.timeout : (enable_d && max_hit));
    elapsed_d     = start_wait ? '0 : (enable_d ? elapsed_inc : bus.elapsed);
    if (start_wait)
      delay_d = DW'(MIN_DELAY_TICKS) + DW'(lfsr[DELAY_RANGE_LOG2-1:0]);
    else if (state == WAIT && tick && delay_cnt != '0)
      delay_d = delay_cnt - 1'b1;
    else
      delay_d = delay_cnt;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      // Edge history tracks the key during reset so a held key gives no edge afterwards.
      req_q           <= bus.request_test;
      stop_q          <= bus.stop_test;
      lfsr            <= LFSR_SEED;
      delay_cnt       <= '0;
      bus.test_active <= 1'b0;
      bus.enable_bcd  <= 1'b0;
      bus.clear_bcd   <= 1'b0;
      bus.false_start <= 1'b0;
      bus.timeout     <= 1'b0;
      bus.busy        <= 1'b0;
      bus.elapsed     <= '0;
    end else begin
      req_q           <= bus.request_test;
      stop_q          <= bus.stop_test;
      lfsr            <= lfsr_step(lfsr);
      delay_cnt       <= delay_d;
      bus.test_active <= test_active_d;
      bus.enable_bcd  <= enable_d;
      bus.clear_bcd   <= clear_d;
      bus.false_start <= false_d;
      bus.timeout     <= timeout_d;
      bus.busy        <= busy_d;
      bus.elapsed     <= elapsed_d;
    end
  end
endmodule
